// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared constants and types for the sequential adder tree (addertree_seq).
//   OPW    : default operand width in bits
//   NOPS   : operands per group, equal to the adder-tree fan-in
//   ACCW   : default accumulator / result width in bits
//   TREEW  : adder-tree output width for the default operand width
//   state_e: sequencing FSM states (FILL collects, SUM folds, DONE presents)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package adder_pkg;

    localparam int OPW  = 7;
    localparam int NOPS = 8;
    localparam int ACCW = 16;

    // Summing eight operands can grow the value by at most three bits.
    function automatic int treeWidth(input int opw);
        return opw + 3;
    endfunction

    localparam int TREEW = treeWidth(OPW);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SUM  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/op_tree8.sv
// -----------------------------------------------------------------------------
// op_tree8
// Purely combinational 8-input unsigned adder tree. Each level widens by one
// bit, so the output never truncates.
//   ops_i : eight OPW-bit operands packed side by side (operand 0 in the LSBs)
//   sum_o : (OPW+3)-bit sum of all eight operands
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module op_tree8 #(
    parameter int OPW = adder_pkg::OPW
) (
    input  logic [8*OPW-1:0] ops_i,
    output logic [OPW+2:0]   sum_o
);

    logic [OPW:0]   levelOne [4];
    logic [OPW+1:0] levelTwo [2];

    // Three levels of pairwise addition: 8 -> 4 -> 2 -> 1, each zero-extended
    // by one bit before adding so that no carry is dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            levelOne[i] = {1'b0, ops_i[(2*i)*OPW +: OPW]}
                        + {1'b0, ops_i[(2*i+1)*OPW +: OPW]};
        end
        for (int i = 0; i < 2; i++) begin
            levelTwo[i] = {1'b0, levelOne[2*i]} + {1'b0, levelOne[2*i+1]};
        end
        sum_o = {1'b0, levelTwo[0]} + {1'b0, levelTwo[1]};
    end

endmodule

// File: rtl/addertree_seq.sv
// -----------------------------------------------------------------------------
// addertree_seq
// Sums an arbitrarily long job of unsigned operands. Operands are collected in
// groups of eight into a register bank, folded in one cycle through op_tree8
// into a wide accumulator, and the job total is presented with a sticky
// overflow flag once the operand marked in_last has been folded in.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_data operand, in_last job end
//   out_valid/out_ready : result handshake
//   result, ovf         : job sum modulo 2^ACCW, sticky overflow
//   busy                : high unless idle in FILL with nothing collected
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module addertree_seq #(
    parameter int OPW  = adder_pkg::OPW,
    parameter int NOPS = adder_pkg::NOPS,
    parameter int ACCW = adder_pkg::ACCW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [OPW-1:0]  in_data,
    input  logic            in_last,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] result,
    output logic            ovf,
    output logic            busy
);

    import adder_pkg::state_e;
    import adder_pkg::FILL;
    import adder_pkg::SUM;
    import adder_pkg::DONE;

    localparam int TW   = adder_pkg::treeWidth(OPW);
    localparam int CNTW = $clog2(NOPS);
    localparam logic [CNTW-1:0] LAST_SLOT = CNTW'(NOPS - 1);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

    state_e          state_q, state_d;
    logic [OPW-1:0]  bank_q [NOPS];
    logic [CNTW-1:0] cnt_q;
    logic [ACCW-1:0] acc_q;
    logic            ovf_q;
    logic            grpLast_q;

    logic [NOPS*OPW-1:0] bankFlat;
    logic [TW-1:0]       treeSum;
    logic [ACCW:0]       accSum;
    logic                accept;
    logic                groupEnd;

    // Flatten the bank for the tree; unwritten slots are already zero because
    // SUM clears the whole bank after every fold.
    always_comb begin
        bankFlat = '0;
        for (int i = 0; i < NOPS; i++) begin
            bankFlat[i*OPW +: OPW] = bank_q[i];
        end
    end

    op_tree8 #(
        .OPW (OPW)
    ) u_tree (
        .ops_i (bankFlat),
        .sum_o (treeSum)
    );

    // One extra bit on the accumulator add captures the carry-out for ovf.
    assign accSum   = {1'b0, acc_q} + {{(ACCW + 1 - TW){1'b0}}, treeSum};
    assign accept   = in_valid && (state_q == FILL);
    assign groupEnd = accept && ((cnt_q == LAST_SLOT) || in_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a group closes on slot 7 or in_last, SUM always lasts
    // one cycle, and DONE waits for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (groupEnd)  state_d = SUM;
            SUM:     state_d = grpLast_q ? DONE : FILL;
            DONE:    if (out_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs come straight from registered state so nothing ripples from the
    // input handshake to the output handshake.
    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == DONE);
        busy      = !((state_q == FILL) && (cnt_q == '0) && (acc_q == '0));
        result    = acc_q;
        ovf       = ovf_q;
    end

    // Datapath: bank writes while filling, fold-and-clear in SUM, and the
    // accumulator is released only when the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NOPS; i++) begin
                bank_q[i] <= '0;
            end
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            grpLast_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        bank_q[cnt_q] <= in_data;
                        cnt_q         <= cnt_q + CNT_ONE;
                    end
                    if (groupEnd) begin
                        grpLast_q <= in_last;
                    end
                end
                SUM: begin
                    acc_q <= accSum[ACCW-1:0];
                    ovf_q <= ovf_q | accSum[ACCW];
                    for (int i = 0; i < NOPS; i++) begin
                        bank_q[i] <= '0;
                    end
                    cnt_q <= '0;
                end
                DONE: begin
                    if (out_ready) begin
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        grpLast_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addertree_seq.sv
// -----------------------------------------------------------------------------
// tb_addertree_seq
// Directed self-checking bench for addertree_seq: one task per scenario, each
// with hand-computed expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_addertree_seq;

    localparam int OPW  = 7;
    localparam int ACCW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic [OPW-1:0]  in_data = '0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ACCW-1:0] result;
    logic            ovf;
    logic            busy;

    int total = 0;
    int bad   = 0;

    addertree_seq #(
        .OPW  (OPW),
        .NOPS (8),
        .ACCW (ACCW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .busy      (busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Present one operand and hold it across exactly one accepting edge.
    task automatic sendOp(input logic [OPW-1:0] d, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++; bad++;
            $display("[TB] FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Bounded wait for the result to appear.
    task automatic waitDone(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_done_timeout out_valid=%0b required=1", name, out_valid);
        end
    endtask

    // Take the result in one cycle.
    task automatic takeResult();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #3;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got rdy=%0b vld=%0b res=%0d ovf=%0b busy=%0b required 1 0 0 0 0",
                     in_ready, out_valid, result, ovf, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_full_group();
        for (int i = 0; i < 8; i++) begin
            sendOp(7'(i), i == 7);
        end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_sum_cycle got vld=%0b busy=%0b required 0 1", out_valid, busy);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_latency got out_valid=%0b required=1", out_valid);
        end
        total++;
        if (result !== 16'd28 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL full_result got %0d ovf=%0b required 28 ovf=0", result, ovf);
        end
        takeResult();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'd0) begin
            bad++;
            $display("[TB] FAIL full_release got vld=%0b busy=%0b res=%0d required 0 0 0", out_valid, busy, result);
        end
    endtask

    task automatic test_two_groups();
        for (int i = 1; i <= 16; i++) begin
            sendOp(7'd1, i == 16);
            if (i == 8 || i == 16) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL two_sum_ready op=%0d got in_ready=%0b required=0", i, in_ready);
                end
            end
        end
        waitDone("two");
        total++;
        if (result !== 16'd16 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL two_result got %0d ovf=%0b required 16 ovf=0", result, ovf);
        end
        takeResult();
    endtask

    task automatic test_partial();
        sendOp(7'd127, 1'b0);
        sendOp(7'd127, 1'b0);
        sendOp(7'd127, 1'b1);
        waitDone("partial");
        total++;
        if (result !== 16'd381 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL partial_result got %0d ovf=%0b required 381 ovf=0", result, ovf);
        end
        takeResult();
        sendOp(7'd5, 1'b1);
        waitDone("stale");
        total++;
        if (result !== 16'd5) begin
            bad++;
            $display("[TB] FAIL stale_slots got %0d required 5", result);
        end
        takeResult();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 520; i++) begin
            sendOp(7'd127, i == 519);
        end
        waitDone("ovf");
        total++;
        if (result !== 16'd504 || ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_result got %0d ovf=%0b required 504 ovf=1", result, ovf);
        end
        takeResult();
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ovf_clear got ovf=%0b required 0", ovf);
        end
    endtask

    task automatic test_back_to_back();
        sendOp(7'd10, 1'b0);
        sendOp(7'd20, 1'b1);
        waitDone("hold");
        in_valid = 1'b1;
        in_data  = 7'd99;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            total++;
            if (result !== 16'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL hold_cycle%0d got res=%0d vld=%0b rdy=%0b required 30 1 0",
                         c, result, out_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        takeResult();
        sendOp(7'd4, 1'b1);
        waitDone("after_hold");
        total++;
        if (result !== 16'd4) begin
            bad++;
            $display("[TB] FAIL after_hold got %0d required 4", result);
        end
        takeResult();
    endtask

    task automatic test_reset_midjob();
        for (int i = 1; i <= 5; i++) begin
            sendOp(7'(i), 1'b0);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midjob_busy got %0b required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'd0 || ovf !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midjob_reset got rdy=%0b vld=%0b res=%0d ovf=%0b busy=%0b required 1 0 0 0 0",
                     in_ready, out_valid, result, ovf, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sendOp(7'd3, 1'b0);
        sendOp(7'd1, 1'b0);
        sendOp(7'd2, 1'b1);
        waitDone("post_reset");
        total++;
        if (result !== 16'd6) begin
            bad++;
            $display("[TB] FAIL post_reset_result got %0d required 6", result);
        end
        takeResult();
    endtask

    // Scenario sequence.
    initial begin
        $display("[TB] starting addertree_seq bench");
        test_reset();
        test_full_group();
        test_two_groups();
        test_partial();
        test_overflow();
        test_back_to_back();
        test_reset_midjob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addertree_seq.md
ADDERTREE_SEQ -- requirements
Module: addertree_seq

Interface
REQ-001 SHALL have parameter OPW, default 7: operand width in bits.
REQ-002 SHALL have parameter NOPS, fixed at 8: operands per group, equal to the adder tree fan-in.
REQ-003 SHALL have parameter ACCW, default 16: accumulator and result width in bits.
REQ-004 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1: in_data holds a valid operand.
REQ-007 SHALL have port in_data  input  OPW: unsigned operand.
REQ-008 SHALL have port in_last  input  1: final operand of the current job; sampled with in_data.
REQ-009 SHALL have port in_ready  output  1: the block can accept an operand.
REQ-010 SHALL have port out_valid  output  1: result and ovf are valid.
REQ-011 SHALL have port out_ready  input  1: the consumer accepts the result.
REQ-012 SHALL have port result  output  ACCW: job sum modulo 2^ACCW.
REQ-013 SHALL have port ovf  output  1: sticky flag, set when the job sum exceeded 2^ACCW-1.
REQ-014 SHALL have port busy  output  1: high in every state except FILL with slot count 0 and accumulator 0.

Function
REQ-015 SHALL implement states FILL, SUM and DONE, with FILL as the reset state.
REQ-016 SHALL drive in_ready=1 only in FILL and out_valid=1 only in DONE, both from registered state.
REQ-017 SHALL, on an accepted operand (in_valid and in_ready high at a rising edge), write in_data to bank slot cnt and increment cnt (range 0..7).
REQ-018 SHALL go from FILL to SUM when the accepted operand is slot 7 or carries in_last=1.
REQ-019 SHALL latch the in_last of the transitioning operand as grp_last.
REQ-020 SHALL treat bank slots not written in a partial group as zero.
REQ-021 SHALL, in SUM (exactly one cycle), compute the combinational 8-operand tree sum (OPW+3 bits, no truncation), add it to the accumulator, and set ovf on carry-out.
REQ-022 SHALL, in SUM, clear every bank slot and cnt.
REQ-023 SHALL go from SUM to DONE if grp_last=1, else back to FILL.
REQ-024 SHALL meet this latency: final operand accepted at edge t gives out_valid=1 from edge t+1 onward.
REQ-025 SHALL hold result and ovf stable in DONE while out_ready=0.
REQ-026 SHALL, on the DONE handshake edge, clear the accumulator and ovf and return to FILL.
REQ-027 SHALL ignore in_valid while in SUM or DONE; no operand is lost because in_ready=0.
REQ-028 SHALL produce result = (sum of all job operands) mod 2^ACCW.
REQ-029 SHALL, once ovf is set in a job, keep ovf=1 until the DONE handshake.

Reset
REQ-030 SHALL, on rst_n low at any time (including mid-FILL or in DONE), force state=FILL, cnt=0, bank=0, accumulator=0, ovf=0, grp_last=0.
REQ-031 SHALL, while in reset, drive in_ready=1, out_valid=0, result=0, ovf=0 and busy=0.
REQ-032 SHALL discard a partially collected job on reset.
REQ-033 SHALL let reset deassertion take effect at the next rising edge with no extra wait cycles.

Structure
REQ-034 SHALL take OPW, NOPS, ACCW, the tree output width (OPW+3) and the state encoding from the shared package adder_pkg.
REQ-035 SHALL isolate the tree as one combinational sub-module, op_tree8: 8 x OPW inputs to an (OPW+3)-bit sum.
REQ-036 SHALL keep the sequencing FSM, bank, counter and accumulator in addertree_seq.

Verification
REQ-037 Bench SHALL drive operands 0,1,2,3,4,5,6,7 with in_last on 7 -> result=28, ovf=0, out_valid one edge after the last accept.
REQ-038 Bench SHALL drive 16 operands of 1 with in_last on the 16th -> two SUM passes, result=16, in_ready low during SUM.
REQ-039 Bench SHALL drive a partial group 127,127,127 with in_last -> result=381, and the next job must not reuse stale slots.
REQ-040 Bench SHALL drive 520 operands of 127 (65 full groups), last on the final operand -> result=504, ovf=1.
REQ-041 Bench SHALL hold out_ready=0 for 10 cycles in DONE -> result and out_valid stable, in_ready=0; after release, the next job starts at 0.
REQ-042 Bench SHALL assert rst_n low after 5 operands of a job -> all outputs at reset values; the following job 3,1,2 with last -> result=6.
